// File: rtl/ps2_pkg.sv
// Shared types and command codes for the PS/2 host-to-device transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    RELEASE,
    DONE,
    FAIL
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the raw PS/2 lines plus a falling-edge strobe on the clock line.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic fe
);

  logic clk_p0, clk_p1, clk_p2;
  logic data_p0, data_p1;

  // Idle lines are high, so reset to 1 to avoid a phantom edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_p0  <= 1'b1;
      clk_p1  <= 1'b1;
      clk_p2  <= 1'b1;
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
    end else begin
      clk_p0  <= clk_in;
      clk_p1  <= clk_p0;
      clk_p2  <= clk_p1;
      data_p0 <= data_in;
      data_p1 <= data_p0;
    end
  end

  assign clk_s  = clk_p1;
  assign data_s = data_p1;
  assign fe     = clk_p2 & ~clk_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, requests to send, shifts one byte
// with odd parity on device falling edges and checks the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int INHIBIT_CYCLES = 10_000,
  parameter int START_TIMEOUT  = 1_500_000,
  parameter int FRAME_TIMEOUT  = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAX_A   = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int MAX_CYC = (MAX_A > FRAME_TIMEOUT) ? MAX_A : FRAME_TIMEOUT;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TIMEOUT - 1);

  if (CLK_HZ < 1 || INHIBIT_CYCLES < 1 || START_TIMEOUT < 1 || FRAME_TIMEOUT < 1) begin : g_param_check
    $error("ps2_host_tx: clock and cycle parameters must be positive");
  end

  ps2_tx_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       idx;
  logic [7:0]       data_q;
  logic             par_q;
  logic             clk_s, data_s, fe;
  logic             timeout, nack;

  ps2_line_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .clk_in  (ps2_clk_in),
    .data_in (ps2_data_in),
    .clk_s   (clk_s),
    .data_s  (data_s),
    .fe      (fe)
  );

  // Open-drain enable for frame position i: data bits, then parity, then released stop bit.
  function automatic logic bit_oe(input logic [3:0] i, input logic [7:0] d, input logic p);
    if (i < 4'd8)       return ~d[i[2:0]];
    else if (i == 4'd8) return ~p;
    else                return 1'b0;
  endfunction

  always_comb begin
    timeout = 1'b0;
    case (state)
      REQ:                 timeout = !fe && (cnt == START_LAST);
      SHIFT, ACK, RELEASE: timeout = (cnt == FRAME_LAST);
      default:             timeout = 1'b0;
    endcase
  end

  assign nack = (state == ACK) && data_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      data_q      <= '0;
      par_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (timeout || nack) begin
        state       <= FAIL;
        err         <= 1'b1;
        busy        <= 1'b0;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: if (tx_start) begin
            data_q     <= tx_data;
            par_q      <= ~^tx_data;
            cnt        <= '0;
            idx        <= '0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end
          INHIBIT: if (cnt == INH_LAST) begin
            cnt         <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            state       <= REQ;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          // The first device falling edge restarts the counter as the whole-frame watchdog.
          REQ: if (fe) begin
            cnt         <= '0;
            idx         <= '0;
            ps2_data_oe <= bit_oe(4'd0, data_q, par_q);
            state       <= SHIFT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          SHIFT: begin
            cnt <= cnt + CNT_W'(1);
            if (fe) begin
              if (idx == 4'd9) begin
                state <= ACK;
              end else begin
                idx         <= idx + 4'd1;
                ps2_data_oe <= bit_oe(idx + 4'd1, data_q, par_q);
              end
            end
          end
          ACK: begin
            cnt   <= cnt + CNT_W'(1);
            state <= RELEASE;
          end
          RELEASE: begin
            cnt <= cnt + CNT_W'(1);
            if (clk_s && data_s) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
          DONE:    state <= IDLE;
          FAIL:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a device BFM clocks frames, a scoreboard queue holds expected outcomes.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 200;
  localparam int ST  = 3000;
  localparam int FR  = 4000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       busy, done, err, ps2_clk_oe, ps2_data_oe;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int         compared = 0;
  int         mismatched = 0;
  int         pulse_cnt = 0;
  longint     cyc = 0;
  longint     rel_cyc = 0;
  logic [10:0] seen_bits = '0;

  typedef struct {
    logic        exp_done;
    logic        chk_bits;
    logic        chk_lat;
    logic [10:0] bits;
  } exp_t;
  exp_t q[$];

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_HZ         (100_000_000),
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (ST),
    .FRAME_TIMEOUT  (FR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Line-level frame as the device should see it: start, LSB-first data, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Scoreboard monitor: every done/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (done || err)) begin
      exp_t e;
      pulse_cnt++;
      chk("pulse_exclusive", done & err, 0);
      chk("busy_at_pulse", busy, 0);
      chk("pulse_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("done_pulse", done, e.exp_done);
        chk("err_pulse", err, !e.exp_done);
        if (e.chk_bits) chk("frame_bits", seen_bits, e.bits);
        if (e.chk_lat)  chk("timeout_latency", cyc - rel_cyc, ST);
      end
    end
  end

  // Device BFM. mode 0: ACK, 1: no ACK, 3: stop clocking while bit 4 is on the line.
  task automatic device_clock(input int half, input int mode);
    repeat (10) @(negedge clk);
    seen_bits[0] = ps2_data_in;
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      if (mode == 3 && k == 5) begin
        repeat (half / 2) @(negedge clk);
        return;
      end
      repeat (half) @(negedge clk);
      seen_bits[k] = ps2_data_in;
      dev_clk_low = 1'b0;
      repeat (half) @(negedge clk);
    end
    if (mode == 0) dev_data_low = 1'b1;
    repeat (half / 2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (half) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (half) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  // mode 2: device never clocks. dup: second tx_start during inhibit. on_done: tx_start with done.
  task automatic send(input logic [7:0] d, input int half, input int mode, input bit dup, input bit on_done);
    int  n;
    int  base;
    bit  got;
    base = pulse_cnt;
    if (mode != 3)
      q.push_back('{exp_done: (mode == 0), chk_bits: (mode <= 1), chk_lat: (mode == 2), bits: frame_of(d)});
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("clk_oe_after_start", ps2_clk_oe, 1);
    n = 1;
    while (ps2_clk_oe && n < INH + 100) begin
      @(negedge clk);
      if (dup && n == INH / 2) begin
        tx_data  = 8'h00;
        tx_start = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
      if (ps2_clk_oe) n++;
    end
    tx_start = 1'b0;
    rel_cyc  = cyc;
    chk("inhibit_len", n, INH);
    chk("start_bit_oe", ps2_data_oe, 1);
    if (mode != 2) device_clock(half, mode);
    if (mode == 3) begin
      chk("abort_busy", busy, 1);
      chk("abort_bit4_oe", ps2_data_oe, !frame_of(d)[5]);
      #3 rst = 1'b1;
      #1;
      chk("abort_clk_oe", ps2_clk_oe, 0);
      chk("abort_data_oe", ps2_data_oe, 0);
      chk("abort_busy_clr", busy, 0);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      return;
    end
    got = 1'b0;
    for (int k = 0; k < ST + FR; k++) begin
      @(negedge clk);
      if (done || err || pulse_cnt != base) begin
        got = 1'b1;
        break;
      end
    end
    chk("pulse_seen", got, 1);
    if (on_done) begin
      chk("done_for_restart", done, 1);
      tx_data  = 8'h11;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      chk("start_on_done_ignored", busy, 0);
    end else begin
      @(negedge clk);
    end
    chk("released_clk_oe", ps2_clk_oe, 0);
    chk("released_data_oe", ps2_data_oe, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (20) @(negedge clk);
    end
    chk("idle_traffic_busy", busy, 0);
    chk("idle_traffic_clk_oe", ps2_clk_oe, 0);

    send(PS2_CMD_ENABLE, 40, 0, 1'b0, 1'b0);
    send(PS2_CMD_RESET,  40, 0, 1'b0, 1'b0);
    send(PS2_CMD_ENABLE, 40, 2, 1'b0, 1'b0);
    send(PS2_CMD_ENABLE, 40, 1, 1'b0, 1'b0);
    send(8'h00,          40, 3, 1'b0, 1'b0);
    send(PS2_CMD_ENABLE, 40, 0, 1'b0, 1'b0);
    send(PS2_CMD_ENABLE, 40, 0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      int         half;
      bit         ack;
      d    = 8'($urandom_range(0, 255));
      half = int'($urandom_range(30, 60));
      ack  = ($urandom_range(0, 3) != 0);
      send(d, half, ack ? 0 : 1, 1'b0, 1'b0);
    end
    send(8'h5A, 35, 0, 1'b0, 1'b1);

    repeat (50) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL global_timeout: simulation still running after 95000 cycles, want finished");
    $fatal(1, "bench did not complete");
  end

endmodule
